// File: rtl/data_mem_if.sv
// data_mem_if: CPU load/store request/response handshake between the CPU (master)
// and the data memory responder (slave).
interface data_mem_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory answering one load/store at a time
// after a fixed wait, with a one-cycle response pulse carrying data and error flag.
module data_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input logic        clk_i,
  input logic        reset_i,
  data_mem_if.slave  bus
);
  localparam int IW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [31:0]       mem [DEPTH_WORDS];
  logic              c_write, c_err, commit;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata;
  logic [ADDR_W-3:0] c_word;
  logic [IW-1:0]     c_idx;
  // with zero latency the commit edge is the accept edge, so the live request is used
  assign c_write = LATENCY == 0 ? bus.req_write : write_q;
  assign c_addr  = LATENCY == 0 ? bus.req_addr  : addr_q;
  assign c_wdata = LATENCY == 0 ? bus.req_wdata : wdata_q;
  assign c_word  = c_addr[ADDR_W-1:2];
  assign c_idx   = c_word[IW-1:0];
  assign c_err   = (c_addr[1:0] != 2'b00) || (32'(c_word) >= DEPTH_WORDS);
  assign commit  = state_d == RESP && state_q != RESP;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        state_d = LATENCY == 0 ? RESP : WAIT;
        cnt_d   = 4'(LATENCY == 0 ? 0 : LATENCY - 1);
      end
      WAIT: begin
        cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
        state_d = cnt_q == 4'd0 ? RESP : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  // memory is written only outside reset, so an aborted store never lands
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && bus.req_valid) begin
        write_q <= bus.req_write;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (commit) begin
        rdata_q <= (c_write || c_err) ? '0 : mem[c_idx];
        err_q   <= c_err;
        if (c_write && !c_err) mem[c_idx] <= c_wdata;
      end
    end
  assign bus.req_ready  = state_q == IDLE;
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: random load/store traffic with random resets against two builds
// (LATENCY=2/256 words and LATENCY=0/128 words), checked by a cycle-numbered reference model.
module tb_data_mem_responder;
  typedef struct {
    bit          wr;
    logic [9:0]  a;
    logic [31:0] d;
  } req_t;
  logic clk = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  int n_done = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask
  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int LAT   = g == 0 ? 2 : 0;
    localparam int DEPTH = g == 0 ? 256 : 128;
    logic rst;
    data_mem_if #(.ADDR_W(10)) bus ();
    data_mem_responder #(.ADDR_W(10), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus.slave)
    );
    initial begin : drive
      logic [31:0] mm [256];
      bit          known [256];
      int          pool [7];
      req_t        dq [$];
      req_t        cur;
      bit          cur_dq, p_wr, p_err, exp_err, rd_known;
      logic [9:0]  p_a;
      logic [31:0] p_d, exp_rd;
      int          cyc, e0, widx;
      pool = '{0, 4, 8, 100, 127, 128, 255};
      for (int i = 0; i < 256; i++) known[i] = 1'b0;
      cyc = 0; e0 = -100; exp_rd = '0; exp_err = 1'b0; rd_known = 1'b1;
      p_wr = 1'b0; p_a = '0; p_d = '0;
      rst = 1'b1;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      dq.push_back('{1'b1, 10'h010, 32'hDEADBEEF});
      dq.push_back('{1'b0, 10'h010, 32'h0});
      dq.push_back('{1'b0, 10'h013, 32'h0});
      dq.push_back('{1'b0, 10'h010, 32'h0});
      dq.push_back('{1'b1, 10'h3FC, 32'hCAFEF00D});
      dq.push_back('{1'b0, 10'h3FC, 32'h0});
      for (int i = 0; i < 7; i++) dq.push_back('{1'b1, 10'(pool[i] * 4), $urandom});
      @(negedge clk);
      for (int k = 0; k < 1500; k++) begin
        check($sformatf("c%0d_ready", g), 32'(bus.req_ready), 32'(cyc >= e0 + LAT + 1));
        check($sformatf("c%0d_rvalid", g), 32'(bus.resp_valid), 32'(cyc == e0 + LAT));
        check($sformatf("c%0d_err", g), 32'(bus.resp_err), 32'(exp_err));
        if (rd_known) check($sformatf("c%0d_rdata", g), bus.resp_rdata, exp_rd);
        rst = k >= 40 && dq.size() == 0 && $urandom_range(29) == 0;
        if (rst) begin
          e0 = -100; exp_rd = '0; exp_err = 1'b0; rd_known = 1'b1;
        end
        if (dq.size() != 0) begin
          cur = dq[0]; cur_dq = 1'b1; bus.req_valid = 1'b1;
        end else begin
          cur_dq = 1'b0;
          cur.wr = 1'($urandom_range(1));
          cur.a  = 10'(pool[$urandom_range(6)] * 4 + ($urandom_range(3) == 0 ? $urandom_range(3, 1) : 0));
          cur.d  = $urandom;
          bus.req_valid = $urandom_range(9) < 7;
        end
        bus.req_write = cur.wr; bus.req_addr = cur.a; bus.req_wdata = cur.d;
        @(posedge clk);
        if (!rst && bus.req_valid && cyc >= e0 + LAT + 1) begin
          e0 = cyc + 1; p_wr = bus.req_write; p_a = bus.req_addr; p_d = bus.req_wdata;
          if (cur_dq) dq.delete(0);
        end
        cyc++;
        if (!rst && cyc == e0 + LAT) begin
          widx  = int'(p_a[9:2]);
          p_err = p_a[1:0] != 2'b00 || widx >= DEPTH;
          if (p_wr && !p_err) begin mm[widx] = p_d; known[widx] = 1'b1; end
          exp_rd   = (p_wr || p_err) ? 32'h0 : mm[widx];
          rd_known = p_wr || p_err || known[widx];
          exp_err  = p_err;
        end
        @(negedge clk);
      end
      n_done++;
    end
  end
  initial begin
    wait (n_done == 2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
